serial_sub_ctrl: RTL

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/sub_pkg.sv | 12 +
 rtl/serial_sub_ctrl_fs_cell.sv | 16 +
 rtl/serial_sub_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
package sub_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Pure combinational subtractor cell.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: LSB first, one fs_cell reused over WIDTH cycles,
// ready/valid handshake on both sides.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr;
    logic             brw;
    logic             cell_d, cell_bout;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    fs_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs, decoded from state only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, serial shifting, borrow chain and bit counter.
    // The counter saturates on the last bit so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr <= a;
                        b_sr <= b;
                        brw  <= borrow_in;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    d_sr <= {cell_d, d_sr[WIDTH-1:1]};
                    brw  <= cell_bout;
                    if (!last_bit) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign diff       = d_sr;
    assign borrow_out = brw;

endmodule
